// File: rtl/core_bus_arbiter.sv
// Merges the core's fetch and data ports onto one bus_master request port.
// One slot per port, round-robin grant, one bus transaction in flight at a time.
module core_bus_arbiter #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] insn_addr,
  input  logic                  insn_start,
  output logic                  insn_ready,
  output logic [DATA_WIDTH-1:0] insn_data,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic                  data_start,
  input  logic                  data_write,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_start,
  output logic                  bus_write,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ready,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  localparam logic GNT_INSN = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  state_t                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    last_q, last_d;
  logic                    load_bus, done;

  logic                    insn_vld_q;
  logic [ADDR_WIDTH-1:0]   insn_addr_q;
  logic                    data_vld_q;
  logic [ADDR_WIDTH-1:0]   data_addr_q;
  logic                    data_write_q;
  logic [DATA_WIDTH-1:0]   data_wdata_q;

  logic [ADDR_WIDTH-1:0]   bus_addr_q;
  logic                    bus_write_q;
  logic [DATA_WIDTH-1:0]   bus_wdata_q;
  logic                    insn_ready_q, data_ready_q;
  logic [DATA_WIDTH-1:0]   insn_data_q, data_rdata_q;
  logic                    overrun_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    load_bus = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (insn_vld_q || data_vld_q) begin
          // On a tie the port that did not win last time goes next.
          grant_d  = (insn_vld_q && data_vld_q) ? ~last_q : data_vld_q;
          last_d   = grant_d;
          load_bus = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= GNT_INSN;
      last_q  <= GNT_DATA;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      insn_vld_q   <= 1'b0;
      insn_addr_q  <= '0;
      data_vld_q   <= 1'b0;
      data_addr_q  <= '0;
      data_write_q <= 1'b0;
      data_wdata_q <= '0;
      bus_addr_q   <= '0;
      bus_write_q  <= 1'b0;
      bus_wdata_q  <= '0;
      insn_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      insn_data_q  <= '0;
      data_rdata_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      // A slot can only be cleared while valid, so clear and accept never collide.
      if (done && grant_q == GNT_INSN) insn_vld_q <= 1'b0;
      if (insn_start && !insn_vld_q) begin
        insn_vld_q  <= 1'b1;
        insn_addr_q <= insn_addr;
      end
      if (done && grant_q == GNT_DATA) data_vld_q <= 1'b0;
      if (data_start && !data_vld_q) begin
        data_vld_q   <= 1'b1;
        data_addr_q  <= data_addr;
        data_write_q <= data_write;
        data_wdata_q <= data_wdata;
      end
      overrun_q <= overrun_q | (insn_start & insn_vld_q) | (data_start & data_vld_q);

      if (load_bus) begin
        bus_addr_q  <= (grant_d == GNT_DATA) ? data_addr_q : insn_addr_q;
        bus_write_q <= (grant_d == GNT_DATA) ? data_write_q : 1'b0;
        bus_wdata_q <= (grant_d == GNT_DATA) ? data_wdata_q : '0;
      end

      insn_ready_q <= done && grant_q == GNT_INSN;
      data_ready_q <= done && grant_q == GNT_DATA;
      if (done && grant_q == GNT_INSN) insn_data_q  <= bus_rdata;
      if (done && grant_q == GNT_DATA) data_rdata_q <= bus_rdata;
    end
  end

  assign bus_start  = (state_q == S_ISSUE);
  assign bus_addr   = bus_addr_q;
  assign bus_write  = bus_write_q;
  assign bus_wdata  = bus_wdata_q;
  assign insn_ready = insn_ready_q;
  assign insn_data  = insn_data_q;
  assign data_ready = data_ready_q;
  assign data_rdata = data_rdata_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter; the bench plays bus_master by hand.
module tb_core_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] insn_addr = '0;
  logic        insn_start = 1'b0;
  logic        insn_ready;
  logic [31:0] insn_data;
  logic [29:0] data_addr = '0;
  logic        data_start = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_wdata = '0;
  logic        data_ready;
  logic [31:0] data_rdata;
  logic [29:0] bus_addr;
  logic        bus_start;
  logic        bus_write;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  core_bus_arbiter #(.ADDR_WIDTH(30), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .insn_addr(insn_addr), .insn_start(insn_start), .insn_ready(insn_ready), .insn_data(insn_data),
    .data_addr(data_addr), .data_start(data_start), .data_write(data_write), .data_wdata(data_wdata),
    .data_ready(data_ready), .data_rdata(data_rdata),
    .bus_addr(bus_addr), .bus_start(bus_start), .bus_write(bus_write), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for bus_start, checks the request, returns bus_ready after dly cycles,
  // then checks the completion pulse on the given port (0 fetch, 1 data).
  task automatic bus_txn(input string tag, input logic [29:0] ea, input logic ew,
                         input logic [31:0] ewd, input logic [31:0] rd, input int dly,
                         input int port, output int lat);
    lat = 0;
    while (!bus_start && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " start"}, bus_start, 1'b1);
    check({tag, " addr"}, bus_addr, ea);
    check({tag, " write"}, bus_write, ew);
    if (ew) check({tag, " wdata"}, bus_wdata, ewd);
    tick();
    check({tag, " start pulse"}, bus_start, 1'b0);
    repeat (dly - 1) tick();
    bus_ready = 1'b1;
    bus_rdata = rd;
    tick();
    bus_ready = 1'b0;
    bus_rdata = '0;
    if (port == 0) begin
      check({tag, " insn_ready"}, insn_ready, 1'b1);
      check({tag, " data_ready"}, data_ready, 1'b0);
      check({tag, " insn_data"}, insn_data, rd);
    end else begin
      check({tag, " data_ready"}, data_ready, 1'b1);
      check({tag, " insn_ready"}, insn_ready, 1'b0);
      check({tag, " data_rdata"}, data_rdata, rd);
    end
  endtask

  initial begin
    int lat;
    int starts;
    logic [31:0] held;

    // Reset state
    tick();
    tick();
    check("rst bus_start", bus_start, 1'b0);
    check("rst bus_addr", bus_addr, 30'd0);
    check("rst insn_data", insn_data, 32'd0);
    check("rst overrun", overrun, 1'b0);
    rst = 1'b0;
    tick();

    // 1: single fetch
    insn_addr = 30'h0000100; insn_start = 1'b1;
    tick();
    insn_start = 1'b0;
    bus_txn("t1", 30'h0000100, 1'b0, 32'd0, 32'hE3A00001, 3, 0, lat);
    check("t1 latency", lat, 1);
    tick();
    check("t1 ready pulse", insn_ready, 1'b0);
    check("t1 data held", insn_data, 32'hE3A00001);

    // 2: simultaneous fetch and write from reset
    rst = 1'b1; tick(); rst = 1'b0; tick();
    insn_addr = 30'h0000180; insn_start = 1'b1;
    data_addr = 30'h0000200; data_write = 1'b1; data_wdata = 32'hDEADBEEF; data_start = 1'b1;
    tick();
    insn_start = 1'b0; data_start = 1'b0; data_write = 1'b0;
    bus_txn("t2 fetch", 30'h0000180, 1'b0, 32'd0, 32'h01020304, 2, 0, lat);
    check("t2 fetch lat", lat, 1);
    bus_txn("t2 write", 30'h0000200, 1'b1, 32'hDEADBEEF, 32'h0, 1, 1, lat);
    check("t2 b2b lat", lat, 1);
    check("t2 insn_data held", insn_data, 32'h01020304);

    // 3: both ports busy, grants alternate starting with fetch
    insn_addr = 30'h0000300; insn_start = 1'b1;
    data_addr = 30'h0000400; data_start = 1'b1;
    tick();
    insn_start = 1'b0; data_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        bus_txn("t3 insn", 30'h0000300, 1'b0, 32'd0, 32'h3000 + i, 1, 0, lat);
      else
        bus_txn("t3 data", 30'h0000400, 1'b0, 32'd0, 32'h4000 + i, 1, 1, lat);
      if (i < 6) begin
        if (i % 2 == 0) insn_start = 1'b1; else data_start = 1'b1;
        tick();
        insn_start = 1'b0; data_start = 1'b0;
      end
    end
    check("t3 overrun", overrun, 1'b0);

    // 4: second data_start while pending
    data_addr = 30'h0000500; data_start = 1'b1;
    tick();
    data_addr = 30'h0000600;
    tick();
    data_start = 1'b0;
    check("t4 overrun set", overrun, 1'b1);
    bus_txn("t4 data", 30'h0000500, 1'b0, 32'd0, 32'h11112222, 2, 1, lat);
    check("t4 lat", lat, 0);
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus_start) starts++;
    end
    check("t4 extra starts", starts, 0);
    check("t4 overrun sticky", overrun, 1'b1);

    // 5: reset during WAIT
    insn_addr = 30'h0000700; insn_start = 1'b1;
    tick();
    insn_start = 1'b0;
    tick();
    check("t5 issued", bus_start, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    check("t5 rst bus_start", bus_start, 1'b0);
    check("t5 rst bus_addr", bus_addr, 30'd0);
    check("t5 rst insn_data", insn_data, 32'd0);
    check("t5 rst data_rdata", data_rdata, 32'd0);
    check("t5 rst overrun", overrun, 1'b0);
    tick();
    rst = 1'b0;
    bus_ready = 1'b1; bus_rdata = 32'hBADBAD;
    tick();
    bus_ready = 1'b0; bus_rdata = '0;
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      if (insn_ready || data_ready || bus_start) starts++;
      tick();
    end
    check("t5 quiet after rst", starts, 0);
    insn_addr = 30'h0000740; insn_start = 1'b1;
    tick();
    insn_start = 1'b0;
    bus_txn("t5 fetch", 30'h0000740, 1'b0, 32'd0, 32'h55AA55AA, 1, 0, lat);
    check("t5 lat", lat, 1);

    // 6: data_start in the data_ready cycle
    data_addr = 30'h0000800; data_start = 1'b1;
    tick();
    data_start = 1'b0;
    bus_txn("t6 first", 30'h0000800, 1'b0, 32'd0, 32'h66660001, 2, 1, lat);
    data_addr = 30'h0000900; data_start = 1'b1;
    tick();
    data_start = 1'b0;
    bus_txn("t6 second", 30'h0000900, 1'b0, 32'd0, 32'h66660002, 1, 1, lat);
    check("t6 lat", lat, 1);
    check("t6 overrun", overrun, 1'b0);
    held = insn_data;
    check("t6 insn_data held", held, 32'h55AA55AA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
